f5_sweep_ctrl: RTL and testbench

F5_SWEEP_CTRL -- requirements
Module: f5_sweep_ctrl

---
 rtl/f5_sweep_ctrl_if.sv | 26 ++
 rtl/f5_sweep_ctrl.sv | 132 +++++++++++++
 tb/tb_f5_sweep_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/f5_sweep_ctrl_if.sv
// Signal bundle between the f5 sweep controller and the two f5 implementations under comparison.
// The slave side is the controller; the master side drives requests and the two results.
interface f5_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic       sa;
  logic       sb;
  logic [2:0] vec;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] mism_cnt;
  logic [2:0] first_bad;
  logic [7:0] tt_a;
  logic [7:0] tt_b;

  modport master (
    output start, abort, sa, sb,
    input  vec, busy, done, pass, mism_cnt, first_bad, tt_a, tt_b
  );

  modport slave (
    input  start, abort, sa, sb,
    output vec, busy, done, pass, mism_cnt, first_bad, tt_a, tt_b
  );
endinterface

// File: rtl/f5_sweep_ctrl.sv
// Walks all eight input vectors through two f5 implementations and compares their results.
// Truth tables, mismatch count and first failing vector are captured for inspection.
module f5_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  f5_sweep_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(SETTLE - 1);

  state_t     state, state_nx;
  logic [3:0] wcnt, wcnt_nx;
  logic [2:0] vec_r, vec_nx;
  logic       busy_r, busy_nx;
  logic       done_r, done_nx;
  logic       pass_r, pass_nx;
  logic [3:0] mism_r, mism_nx;
  logic [2:0] first_r, first_nx;
  logic [7:0] tt_a_r, tt_a_nx;
  logic [7:0] tt_b_r, tt_b_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      wcnt    <= '0;
      vec_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      mism_r  <= '0;
      first_r <= '0;
      tt_a_r  <= '0;
      tt_b_r  <= '0;
    end else begin
      state   <= state_nx;
      wcnt    <= wcnt_nx;
      vec_r   <= vec_nx;
      busy_r  <= busy_nx;
      done_r  <= done_nx;
      pass_r  <= pass_nx;
      mism_r  <= mism_nx;
      first_r <= first_nx;
      tt_a_r  <= tt_a_nx;
      tt_b_r  <= tt_b_nx;
    end
  end

  // busy and done are derived from the next state so they are registered alongside it.
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    vec_nx   = vec_r;
    pass_nx  = pass_r;
    mism_nx  = mism_r;
    first_nx = first_r;
    tt_a_nx  = tt_a_r;
    tt_b_nx  = tt_b_r;

    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          vec_nx   = '0;
          wcnt_nx  = '0;
          tt_a_nx  = '0;
          tt_b_nx  = '0;
          mism_nx  = '0;
          first_nx = '0;
          pass_nx  = 1'b0;
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.abort) begin
          vec_nx   = '0;
          state_nx = ST_IDLE;
        end else begin
          wcnt_nx = wcnt + 4'd1;
          if (wcnt == WAIT_LAST) state_nx = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        // Abort wins here, so the vector being sampled is never recorded.
        if (bus.abort) begin
          vec_nx   = '0;
          state_nx = ST_IDLE;
        end else begin
          tt_a_nx[vec_r] = bus.sa;
          tt_b_nx[vec_r] = bus.sb;
          if (bus.sa != bus.sb) begin
            if (mism_r == 4'd0) first_nx = vec_r;
            if (mism_r != 4'd8) mism_nx = mism_r + 4'd1;
          end
          if (vec_r != 3'd7) begin
            vec_nx   = vec_r + 3'd1;
            wcnt_nx  = '0;
            state_nx = ST_WAIT;
          end else begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        pass_nx  = (mism_r == 4'd0);
        vec_nx   = '0;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase

    busy_nx = (state_nx == ST_WAIT) || (state_nx == ST_SAMPLE);
    done_nx = (state_nx == ST_DONE);
  end

  assign bus.vec       = vec_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.mism_cnt  = mism_r;
  assign bus.first_bad = first_r;
  assign bus.tt_a      = tt_a_r;
  assign bus.tt_b      = tt_b_r;

endmodule

// File: tb/tb_f5_sweep_ctrl.sv
// Directed bench for f5_sweep_ctrl: one controller with SETTLE=1 and one with SETTLE=3,
// each fed by a table-based f5 (sa) and a hand-simplified f5 equation (sb).
module tb_f5_sweep_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   mode;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] f5_tt = 8'h4E;

  always #5 clk = ~clk;

  f5_sweep_ctrl_if b1();
  f5_sweep_ctrl_if b3();

  // mode 0: both f5; mode 1: sb tied low; mode 2: sa tied high
  function automatic logic f5_eq(input logic [2:0] v);
    return (~v[2] & (v[1] | v[0])) | (v[2] & v[1] & ~v[0]);
  endfunction

  assign b1.sa = (mode == 2) ? 1'b1 : f5_tt[b1.vec];
  assign b1.sb = (mode == 1) ? 1'b0 : f5_eq(b1.vec);
  assign b3.sa = (mode == 2) ? 1'b1 : f5_tt[b3.vec];
  assign b3.sb = (mode == 1) ? 1'b0 : f5_eq(b3.vec);

  f5_sweep_ctrl #(.SETTLE(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  f5_sweep_ctrl #(.SETTLE(3)) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Leaves the bench #1 after the accepting edge, i.e. inside cycle 1 of the sweep.
  task automatic start_pulse1();
    @(negedge clk);
    b1.start = 1'b1;
    @(posedge clk);
    #1;
    b1.start = 1'b0;
  endtask

  task automatic sweep1(output int done_cyc, output int done_n);
    done_cyc = 0;
    done_n   = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk);
        #1;
      end
      if (b1.done === 1'b1) begin
        done_n++;
        if (done_cyc == 0) done_cyc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (b1.vec !== 3'd0) begin errors++; $display("[TB] FAIL reset_vec got %0h want 0", b1.vec); end
    checks++; if (b1.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", b1.busy); end
    checks++; if (b1.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", b1.done); end
    checks++; if (b1.pass !== 1'b0) begin errors++; $display("[TB] FAIL reset_pass got %b want 0", b1.pass); end
    checks++; if (b1.mism_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_mism got %0d want 0", b1.mism_cnt); end
    checks++; if (b1.first_bad !== 3'd0) begin errors++; $display("[TB] FAIL reset_first got %0d want 0", b1.first_bad); end
    checks++; if (b1.tt_a !== 8'h00 || b1.tt_b !== 8'h00) begin errors++; $display("[TB] FAIL reset_tt got %h/%h want 00/00", b1.tt_a, b1.tt_b); end
    checks++; if (b3.vec !== 3'd0 || b3.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_dut3 got vec %0d busy %b want 0/0", b3.vec, b3.busy); end
    reset = 1'b0;
  endtask

  task automatic test_equiv_sweep();
    int dc, dn;
    mode = 0;
    start_pulse1();
    checks++; if (b1.busy !== 1'b1 || b1.vec !== 3'd0) begin errors++; $display("[TB] FAIL equiv_cycle1 got busy %b vec %0d want 1/0", b1.busy, b1.vec); end
    sweep1(dc, dn);
    checks++; if (dc != 17) begin errors++; $display("[TB] FAIL equiv_done_cycle got %0d want 17", dc); end
    checks++; if (dn != 1) begin errors++; $display("[TB] FAIL equiv_done_count got %0d want 1", dn); end
    checks++; if (b1.tt_a !== 8'h4E || b1.tt_b !== 8'h4E) begin errors++; $display("[TB] FAIL equiv_tt got %h/%h want 4e/4e", b1.tt_a, b1.tt_b); end
    checks++; if (b1.mism_cnt !== 4'd0) begin errors++; $display("[TB] FAIL equiv_mism got %0d want 0", b1.mism_cnt); end
    checks++; if (b1.pass !== 1'b1) begin errors++; $display("[TB] FAIL equiv_pass got %b want 1", b1.pass); end
    checks++; if (b1.vec !== 3'd0 || b1.busy !== 1'b0) begin errors++; $display("[TB] FAIL equiv_idle got vec %0d busy %b want 0/0", b1.vec, b1.busy); end
  endtask

  task automatic test_mismatch();
    int dc, dn;
    mode = 1;
    start_pulse1();
    checks++; if (b1.pass !== 1'b0) begin errors++; $display("[TB] FAIL mism_pass_cleared got %b want 0", b1.pass); end
    sweep1(dc, dn);
    checks++; if (dc != 17 || dn != 1) begin errors++; $display("[TB] FAIL mism_done got cycle %0d count %0d want 17/1", dc, dn); end
    checks++; if (b1.tt_a !== 8'h4E) begin errors++; $display("[TB] FAIL mism_tt_a got %h want 4e", b1.tt_a); end
    checks++; if (b1.tt_b !== 8'h00) begin errors++; $display("[TB] FAIL mism_tt_b got %h want 00", b1.tt_b); end
    checks++; if (b1.mism_cnt !== 4'd4) begin errors++; $display("[TB] FAIL mism_count got %0d want 4", b1.mism_cnt); end
    checks++; if (b1.first_bad !== 3'd1) begin errors++; $display("[TB] FAIL mism_first got %0d want 1", b1.first_bad); end
    checks++; if (b1.pass !== 1'b0) begin errors++; $display("[TB] FAIL mism_pass got %b want 0", b1.pass); end
  endtask

  task automatic test_settle3();
    int dc, dn, changes, bad;
    logic [2:0] prev;
    mode = 0;
    dc = 0; dn = 0; changes = 0; bad = 0;
    @(negedge clk);
    b3.start = 1'b1;
    @(posedge clk);
    #1;
    b3.start = 1'b0;
    prev = b3.vec;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk);
        #1;
      end
      if (cyc <= 33 && b3.vec !== prev) begin
        changes++;
        if ((cyc - 1) % 4 != 0) bad++;
      end
      prev = b3.vec;
      if (b3.done === 1'b1) begin
        dn++;
        if (dc == 0) dc = cyc;
      end
    end
    checks++; if (dc != 33) begin errors++; $display("[TB] FAIL settle3_done_cycle got %0d want 33", dc); end
    checks++; if (dn != 1) begin errors++; $display("[TB] FAIL settle3_done_count got %0d want 1", dn); end
    checks++; if (changes != 7 || bad != 0) begin errors++; $display("[TB] FAIL settle3_vec_steps got %0d changes %0d off-grid want 7/0", changes, bad); end
    checks++; if (b3.tt_a !== 8'h4E || b3.pass !== 1'b1) begin errors++; $display("[TB] FAIL settle3_result got tt %h pass %b want 4e/1", b3.tt_a, b3.pass); end
  endtask

  task automatic test_back_to_back();
    int dc, dn;
    logic busy18, busy19;
    mode = 0;
    dc = 0; dn = 0; busy18 = 1'bx; busy19 = 1'bx;
    @(negedge clk);
    b1.start = 1'b1;
    @(posedge clk);
    #1;
    for (int cyc = 1; cyc <= 19; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk);
        #1;
      end
      if (b1.done === 1'b1) begin
        dn++;
        if (dc == 0) dc = cyc;
      end
      if (cyc == 18) busy18 = b1.busy;
      if (cyc == 19) busy19 = b1.busy;
    end
    b1.start = 1'b0;
    checks++; if (dn != 1 || dc != 17) begin errors++; $display("[TB] FAIL held_done got count %0d cycle %0d want 1/17", dn, dc); end
    checks++; if (busy18 !== 1'b0) begin errors++; $display("[TB] FAIL held_idle_gap got busy %b want 0", busy18); end
    checks++; if (busy19 !== 1'b1) begin errors++; $display("[TB] FAIL held_restart got busy %b want 1", busy19); end
    apply_reset();
  endtask

  task automatic test_abort();
    int dn;
    logic pass_seen;
    mode = 2;
    dn = 0; pass_seen = 1'b0;
    start_pulse1();
    for (int cyc = 2; cyc <= 10; cyc++) begin
      @(posedge clk);
      #1;
    end
    checks++; if (b1.vec !== 3'd4 || b1.busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_pre got vec %0d busy %b want 4/1", b1.vec, b1.busy); end
    b1.abort = 1'b1;
    @(posedge clk);
    #1;
    b1.abort = 1'b0;
    checks++; if (b1.busy !== 1'b0 || b1.vec !== 3'd0) begin errors++; $display("[TB] FAIL abort_idle got busy %b vec %0d want 0/0", b1.busy, b1.vec); end
    checks++; if (b1.tt_a !== 8'h0F) begin errors++; $display("[TB] FAIL abort_tt_a got %h want 0f", b1.tt_a); end
    checks++; if (b1.tt_b !== 8'h0E) begin errors++; $display("[TB] FAIL abort_tt_b got %h want 0e", b1.tt_b); end
    checks++; if (b1.mism_cnt !== 4'd1 || b1.first_bad !== 3'd0) begin errors++; $display("[TB] FAIL abort_partial got mism %0d first %0d want 1/0", b1.mism_cnt, b1.first_bad); end
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk);
      #1;
      if (b1.done === 1'b1) dn++;
      if (b1.pass === 1'b1) pass_seen = 1'b1;
    end
    checks++; if (dn != 0) begin errors++; $display("[TB] FAIL abort_no_done got %0d pulses want 0", dn); end
    checks++; if (pass_seen !== 1'b0) begin errors++; $display("[TB] FAIL abort_pass got 1 want 0"); end
  endtask

  task automatic test_reset_mid();
    int dn, busy_n;
    mode = 0;
    dn = 0; busy_n = 0;
    start_pulse1();
    for (int cyc = 2; cyc <= 5; cyc++) begin
      @(posedge clk);
      #1;
    end
    checks++; if (b1.tt_a !== 8'h02 || b1.vec !== 3'd2) begin errors++; $display("[TB] FAIL rmid_pre got tt %h vec %0d want 02/2", b1.tt_a, b1.vec); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (b1.vec !== 3'd0 || b1.busy !== 1'b0 || b1.done !== 1'b0 || b1.pass !== 1'b0) begin errors++; $display("[TB] FAIL rmid_async_ctl got vec %0d busy %b done %b pass %b want 0", b1.vec, b1.busy, b1.done, b1.pass); end
    checks++; if (b1.tt_a !== 8'h00 || b1.tt_b !== 8'h00 || b1.mism_cnt !== 4'd0 || b1.first_bad !== 3'd0) begin errors++; $display("[TB] FAIL rmid_async_data got tt %h/%h mism %0d first %0d want 0", b1.tt_a, b1.tt_b, b1.mism_cnt, b1.first_bad); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk);
      #1;
      if (b1.done === 1'b1) dn++;
      if (b1.busy === 1'b1) busy_n++;
    end
    checks++; if (dn != 0 || busy_n != 0) begin errors++; $display("[TB] FAIL rmid_after got done %0d busy %0d want 0/0", dn, busy_n); end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset    = 1'b1;
    mode     = 0;
    b1.start = 1'b0;
    b1.abort = 1'b0;
    b3.start = 1'b0;
    b3.abort = 1'b0;
    test_reset();
    test_equiv_sweep();
    test_mismatch();
    test_settle3();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
